// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, variable-latency memory between the
// core's instruction-fetch port and data port. One transaction is in flight at a
// time. Data accesses win arbitration. A burst counter stops data from starving a
// waiting fetch. All outputs are registered.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_DBURST = 4     // must be >= 1
) (
    input  logic              clk,
    input  logic              rst,        // asynchronous, active low
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int                CNT_W    = $clog2(MAX_DBURST + 1);
    localparam logic [CNT_W-1:0]  DCNT_MAX = CNT_W'(MAX_DBURST);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] dcnt;
    logic             if_elig, dm_elig;
    logic             grant_i, grant_d, done_i, done_d;

    // A requester still holds req in the cycle its ready pulses; that request is
    // already served, so it must not be granted a second time.
    assign if_elig = if_req && !if_ready;
    assign dm_elig = dm_req && !dm_ready;

    // Next-state: arbitrate in IDLE, wait for the memory ack while serving
    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        done_i    = 1'b0;
        done_d    = 1'b0;
        case (state)
            IDLE: begin
                if (dm_elig && (!if_elig || dcnt < DCNT_MAX)) begin
                    grant_d   = 1'b1;
                    state_nxt = SERVE_D;
                end else if (if_elig) begin
                    grant_i   = 1'b1;
                    state_nxt = SERVE_I;
                end
            end
            SERVE_I: begin
                if (mem_ack) begin
                    done_i    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            SERVE_D: begin
                if (mem_ack) begin
                    done_d    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Consecutive data grants seen by a waiting fetch; reset when fetch is served or gone
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dcnt <= '0;
        end else if (!if_req || grant_i) begin
            dcnt <= '0;
        end else if (grant_d && dcnt != DCNT_MAX) begin
            dcnt <= dcnt + 1'b1;
        end
    end

    // Memory request latch on grant, ready pulses and read-data capture on ack
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ready  <= 1'b0;
            dm_ready  <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            busy      <= 1'b0;
        end else begin
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            busy     <= (state_nxt != IDLE);
            if (grant_d) begin
                mem_req   <= 1'b1;
                mem_we    <= dm_we;
                mem_addr  <= dm_addr;
                mem_wdata <= dm_wdata;
            end else if (grant_i) begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
            end else if (done_i || done_d) begin
                mem_req   <= 1'b0;
            end
            if (done_i) begin
                if_ready <= 1'b1;
                if_rdata <= mem_rdata;
            end
            if (done_d) begin
                dm_ready <= 1'b1;
                // a store returns nothing; keep the last load value visible
                if (!mem_we) dm_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of fetch, priority, store and reset cases,
// then randomized requesters and a random-latency memory checked every cycle
// against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, dm_req, dm_we, mem_ack;
    logic [AW-1:0] if_addr, dm_addr;
    logic [DW-1:0] dm_wdata, mem_rdata;
    logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic          if_ready, dm_ready, mem_req, mem_we, busy;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DBURST(MAXB)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: the transaction in flight plus the visible results
    bit            m_busy, m_src_d, m_we, m_if_ready, m_dm_ready;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_if_rdata, m_dm_rdata;
    int            m_dcnt;

    // environment: requester / memory-responder bookkeeping and backing store
    bit            i_out, d_out, r_act;
    int            r_cnt, r_lat;
    logic [DW-1:0] mem [logic [AW-1:0]];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic model_clear();
        m_busy = 0; m_src_d = 0; m_we = 0; m_if_ready = 0; m_dm_ready = 0;
        m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_dm_rdata = '0; m_dcnt = 0;
        i_out = 0; d_out = 0; r_act = 0; r_cnt = 0; r_lat = 0;
    endtask

    // Async reset mid-cycle: every output must clear before the next edge.
    // Called at posedge+1; returns at posedge+1 with reset released.
    task automatic do_reset(input string tag);
        #1 rst = 1'b0;
        #1;
        chk({tag, ".mem_req"},   32'(mem_req),  0);
        chk({tag, ".mem_we"},    32'(mem_we),   0);
        chk({tag, ".mem_addr"},  mem_addr,      0);
        chk({tag, ".mem_wdata"}, mem_wdata,     0);
        chk({tag, ".if_ready"},  32'(if_ready), 0);
        chk({tag, ".dm_ready"},  32'(dm_ready), 0);
        chk({tag, ".if_rdata"},  if_rdata,      0);
        chk({tag, ".dm_rdata"},  dm_rdata,      0);
        chk({tag, ".busy"},      32'(busy),     0);
        if_req = 0; dm_req = 0; dm_we = 0; mem_ack = 0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
        model_clear();
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Advance the model across one clock edge using the inputs held before it
    task automatic model_step();
        bit ei, ed, gi, gd;
        ei = if_req && !m_if_ready;
        ed = dm_req && !m_dm_ready;
        gi = 0;
        gd = 0;
        m_if_ready = 0;
        m_dm_ready = 0;
        if (m_busy) begin
            if (mem_ack) begin
                m_busy = 0;
                if (m_src_d) begin
                    m_dm_ready = 1;
                    if (!m_we) m_dm_rdata = mem_rdata;
                end else begin
                    m_if_ready = 1;
                    m_if_rdata = mem_rdata;
                end
            end
        end else if (ed && (!ei || m_dcnt < MAXB)) gd = 1;
        else if (ei) gi = 1;
        if (gd) begin
            m_busy = 1; m_src_d = 1; m_we = dm_we; m_addr = dm_addr; m_wdata = dm_wdata;
        end
        if (gi) begin
            m_busy = 1; m_src_d = 0; m_we = 0; m_addr = if_addr; m_wdata = '0;
        end
        if (!if_req || gi) m_dcnt = 0;
        else if (gd)       m_dcnt = (m_dcnt < MAXB) ? m_dcnt + 1 : MAXB;
    endtask

    task automatic check_outputs();
        chk("rnd.mem_req",  32'(mem_req),  32'(m_busy));
        chk("rnd.busy",     32'(busy),     32'(m_busy));
        chk("rnd.if_ready", 32'(if_ready), 32'(m_if_ready));
        chk("rnd.dm_ready", 32'(dm_ready), 32'(m_dm_ready));
        chk("rnd.if_rdata", if_rdata,      m_if_rdata);
        chk("rnd.dm_rdata", dm_rdata,      m_dm_rdata);
        if (m_busy) begin
            chk("rnd.mem_addr",  mem_addr,    m_addr);
            chk("rnd.mem_we",    32'(mem_we), 32'(m_we));
            chk("rnd.mem_wdata", mem_wdata,   m_wdata);
        end
    endtask

    // Random core requesters and random-latency memory reacting to the DUT
    task automatic drive_env();
        if (if_ready) i_out = 0;
        if (!i_out && $urandom_range(2) == 0) begin
            i_out   = 1;
            if_addr = 32'h0040_0000 + 32'($urandom_range(63) << 2);
        end else if (i_out && $urandom_range(15) == 0) begin
            i_out = 0;
        end else if (i_out && $urandom_range(3) == 0) begin
            if_addr = 32'h0040_0000 + 32'($urandom_range(63) << 2);
        end
        if_req = i_out;

        if (dm_ready) d_out = 0;
        if (!d_out && $urandom_range(1) == 0) begin
            d_out    = 1;
            dm_we    = 1'($urandom_range(1));
            dm_addr  = 32'h1001_0000 + 32'($urandom_range(15) << 2);
            dm_wdata = $urandom;
        end else if (d_out && $urandom_range(5) == 0) begin
            dm_we    = 1'($urandom_range(1));
            dm_addr  = 32'h1001_0000 + 32'($urandom_range(15) << 2);
            dm_wdata = $urandom;
        end
        dm_req = d_out;

        if (mem_req) begin
            if (!r_act) begin
                r_act = 1;
                r_cnt = 0;
                r_lat = $urandom_range(4, 1);
            end
            r_cnt++;
            if (r_cnt == r_lat) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_rd(mem_addr);
                if (mem_we) mem[mem_addr] = mem_wdata;
                r_act = 0;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
            end
        end else begin
            r_act     = 0;
            mem_ack   = ($urandom_range(3) == 0);   // stray ack while idle
            mem_rdata = $urandom;
        end
    endtask

    initial begin
        rst = 1'b1;
        if_req = 0; dm_req = 0; dm_we = 0; mem_ack = 0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
        model_clear();
        tick();
        do_reset("rst0");

        // fetch with ack in the second cycle of mem_req
        if_req = 1; if_addr = 32'h0040_0000;
        tick();
        chk("fetch.mem_req",  32'(mem_req),  1);
        chk("fetch.mem_addr", mem_addr,      32'h0040_0000);
        chk("fetch.mem_we",   32'(mem_we),   0);
        chk("fetch.busy",     32'(busy),     1);
        tick();
        chk("fetch.addr_hold", mem_addr,      32'h0040_0000);
        chk("fetch.no_ready",  32'(if_ready), 0);
        mem_ack = 1; mem_rdata = 32'h2008_0005;
        tick();
        chk("fetch.if_ready", 32'(if_ready), 1);
        chk("fetch.if_rdata", if_rdata,      32'h2008_0005);
        chk("fetch.req_drop", 32'(mem_req),  0);
        chk("fetch.bubble",   32'(busy),     0);
        if_req = 0; mem_ack = 0; mem_rdata = '0;
        tick();
        chk("fetch.pulse_end", 32'(if_ready), 0);
        chk("fetch.rdata_hold", if_rdata,     32'h2008_0005);

        // simultaneous fetch and load: data first, then fetch, each once
        if_req = 1; if_addr = 32'h0040_0004;
        dm_req = 1; dm_we = 0; dm_addr = 32'h1001_0004;
        tick();
        chk("prio.d_addr", mem_addr,    32'h1001_0004);
        chk("prio.d_we",   32'(mem_we), 0);
        mem_ack = 1; mem_rdata = 32'h1234_5678;
        tick();
        chk("prio.dm_ready", 32'(dm_ready), 1);
        chk("prio.dm_rdata", dm_rdata,      32'h1234_5678);
        chk("prio.if_wait",  32'(if_ready), 0);
        dm_req = 0; mem_ack = 0;
        tick();
        chk("prio.i_req",     32'(mem_req),  1);
        chk("prio.i_addr",    mem_addr,      32'h0040_0004);
        chk("prio.dm_single", 32'(dm_ready), 0);
        mem_ack = 1; mem_rdata = 32'h8C09_0000;
        tick();
        chk("prio.if_ready", 32'(if_ready), 1);
        chk("prio.if_rdata", if_rdata,      32'h8C09_0000);
        if_req = 0; mem_ack = 0;
        tick();
        chk("prio.idle_req", 32'(mem_req),  0);
        chk("prio.if_single", 32'(if_ready), 0);
        tick();
        chk("prio.no_dup", 32'(mem_req), 0);

        // store held three cycles; inputs change after grant and must be ignored
        dm_req = 1; dm_we = 1; dm_addr = 32'h1001_0000; dm_wdata = 32'hDEAD_BEEF;
        tick();
        chk("store.mem_we", 32'(mem_we), 1);
        dm_addr = 32'hFFFF_0000; dm_wdata = 32'h0;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("store.addr_hold",  mem_addr,    32'h1001_0000);
            chk("store.wdata_hold", mem_wdata,   32'hDEAD_BEEF);
            chk("store.we_hold",    32'(mem_we), 1);
        end
        mem_ack = 1; mem_rdata = 32'hBAD0_BAD0;
        tick();
        chk("store.dm_ready",   32'(dm_ready), 1);
        chk("store.rdata_keep", dm_rdata,      32'h1234_5678);
        dm_req = 0; dm_we = 0; mem_ack = 0;
        tick();
        chk("store.pulse_end", 32'(dm_ready), 0);

        // reset while a request waits for ack, then a clean first grant
        dm_req = 1; dm_we = 0; dm_addr = 32'h1001_0008;
        tick();
        chk("abort.mem_req", 32'(mem_req), 1);
        do_reset("abort");
        if_req = 1; if_addr = 32'h0040_0040;
        tick();
        chk("abort.regrant",  32'(mem_req), 1);
        chk("abort.addr",     mem_addr,     32'h0040_0040);
        chk("abort.wdata",    mem_wdata,    0);
        mem_ack = 1; mem_rdata = 32'h0000_0001;
        tick();
        chk("abort.if_ready", 32'(if_ready), 1);
        if_req = 0; mem_ack = 0;
        tick();
        do_reset("pre_rnd");

        // randomized traffic against the reference model
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk);
            model_step();
            #1;
            check_outputs();
            drive_env();
            if ($urandom_range(399) == 0) do_reset("rnd_rst");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
